// File: rtl/tpx3_packet_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tpx3_packet_assembler
// Description : Pairs upper/lower Timepix3 half-words from the receiver FIFO
//               into 48-bit packets on a valid/ready stream; counts drops.
// Revision    : 1.0 - initial release
// ============================================================================
module tpx3_packet_assembler #(
    parameter logic [6:0]  DATA_IDENTIFIER = 7'd0,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        ENABLE,
    input  logic        CNT_CLR,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic [47:0] PKT_DATA,
    output logic        PKT_VALID,
    input  logic        PKT_READY,
    output logic [7:0]  ID_ERR_CNT,
    output logic [7:0]  SYNC_ERR_CNT,
    output logic [7:0]  TIMEOUT_CNT,
    output logic        BUSY
);

    localparam logic [1:0]  c_ST_WAIT_HI = 2'd0;
    localparam logic [1:0]  c_ST_WAIT_LO = 2'd1;
    localparam logic [1:0]  c_ST_OUT     = 2'd2;
    localparam logic [15:0] c_TMO_LIMIT  = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [23:0] r_upper;
    logic [15:0] r_tmo;
    logic [47:0] r_pkt_data;
    logic        r_pkt_valid;
    logic [7:0]  r_id_err_cnt;
    logic [7:0]  r_sync_err_cnt;
    logic [7:0]  r_timeout_cnt;

    logic        w_pop;
    logic        w_id_ok;
    logic        w_half;
    logic        w_vpop;
    logic [15:0] w_tmo_next;
    logic        w_tmo_expire;
    logic        w_id_err_ev;
    logic        w_sync_err_ev;

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        w_pop         = ((r_state == c_ST_WAIT_HI) || (r_state == c_ST_WAIT_LO))
                        && ENABLE && !FIFO_EMPTY && BUS_RST_N;
        w_id_ok       = (FIFO_DATA[31:25] == DATA_IDENTIFIER);
        w_half        = FIFO_DATA[24];
        w_vpop        = w_pop && w_id_ok;
        w_tmo_next    = r_tmo + 16'd1;
        // Any valid-ID pop in WAIT_LO pre-empts an expiry in the same cycle
        w_tmo_expire  = (r_state == c_ST_WAIT_LO) && !w_vpop && (w_tmo_next == c_TMO_LIMIT);
        w_id_err_ev   = w_pop && !w_id_ok;
        w_sync_err_ev = w_vpop && (((r_state == c_ST_WAIT_HI) && !w_half) ||
                                   ((r_state == c_ST_WAIT_LO) &&  w_half));
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state     <= c_ST_WAIT_HI;
            r_upper     <= 24'd0;
            r_tmo       <= 16'd0;
            r_pkt_data  <= 48'd0;
            r_pkt_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_WAIT_HI: begin
                    if (w_vpop && w_half) begin
                        r_upper <= FIFO_DATA[23:0];
                        r_tmo   <= 16'd0;
                        r_state <= c_ST_WAIT_LO;
                    end
                end
                c_ST_WAIT_LO: begin
                    if (w_vpop && !w_half) begin
                        r_pkt_data  <= {r_upper, FIFO_DATA[23:0]};
                        r_pkt_valid <= 1'b1;
                        r_state     <= c_ST_OUT;
                    end else if (w_vpop) begin
                        r_upper <= FIFO_DATA[23:0];
                        r_tmo   <= 16'd0;
                    end else if (w_tmo_expire) begin
                        r_upper <= 24'd0;
                        r_tmo   <= 16'd0;
                        r_state <= c_ST_WAIT_HI;
                    end else begin
                        r_tmo <= w_tmo_next;
                    end
                end
                c_ST_OUT: begin
                    if (PKT_READY) begin
                        r_pkt_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_HI;
                    end
                end
                default: begin
                    r_pkt_valid <= 1'b0;
                    r_state     <= c_ST_WAIT_HI;
                end
            endcase
        end
    end

    // Clear wins over a coincident increment
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N || CNT_CLR) begin
            r_id_err_cnt   <= 8'd0;
            r_sync_err_cnt <= 8'd0;
            r_timeout_cnt  <= 8'd0;
        end else begin
            if (w_id_err_ev)   r_id_err_cnt   <= f_sat_inc(r_id_err_cnt);
            if (w_sync_err_ev) r_sync_err_cnt <= f_sat_inc(r_sync_err_cnt);
            if (w_tmo_expire)  r_timeout_cnt  <= f_sat_inc(r_timeout_cnt);
        end
    end

    assign FIFO_READ    = w_pop;
    assign PKT_DATA     = r_pkt_data;
    assign PKT_VALID    = r_pkt_valid;
    assign ID_ERR_CNT   = r_id_err_cnt;
    assign SYNC_ERR_CNT = r_sync_err_cnt;
    assign TIMEOUT_CNT  = r_timeout_cnt;
    assign BUSY         = (r_state != c_ST_WAIT_HI);

endmodule
`default_nettype wire

// File: doc/tpx3_packet_assembler.md
Name: tpx3_packet_assembler

Overview:
- Sits directly downstream of the per-link Timepix3 receiver core and drains its 32-bit FIFO output port.
- Each FIFO word carries a 7-bit data identifier and a 25-bit front-end field: bit 24 is the half flag (1 = upper/first half), bits 23:0 are payload.
- The block pairs upper/lower halves into complete 48-bit Timepix3 packets and presents them on a valid/ready stream for the event builder.
- It also drops and counts malformed sequences, identifier mismatches and half-packet timeouts.

Parameters:
- DATA_IDENTIFIER, 0: expected value of FIFO_DATA[31:25]; words with any other value are dropped.
- TIMEOUT_CYCLES, 255: maximum cycles allowed in WAIT_LO before the stored upper half is discarded. Legal range 1..65535.

Ports:
- BUS_CLK  in  1  single clock for all logic; same domain as the receiver FIFO read side.
- BUS_RST_N  in  1  synchronous, active-low reset.
- ENABLE  in  1  1 = drain FIFO; 0 = no new pops (a packet already in OUT still completes its handshake).
- CNT_CLR  in  1  synchronous clear of all error counters.
- FIFO_EMPTY  in  1  receiver FIFO empty; FIFO is first-word-fall-through.
- FIFO_DATA  in  32  head word of FIFO, valid while FIFO_EMPTY=0.
- FIFO_READ  out  1  pop strobe, one word per asserted cycle.
- PKT_DATA  out  48  assembled packet {upper[23:0], lower[23:0]}.
- PKT_VALID  out  1  packet available.
- PKT_READY  in  1  consumer accepts packet.
- ID_ERR_CNT  out  8  words dropped for identifier mismatch, saturating.
- SYNC_ERR_CNT  out  8  sequence errors, saturating.
- TIMEOUT_CNT  out  8  upper halves discarded on timeout, saturating.
- BUSY  out  1  1 while state is not WAIT_HI.

Behaviour:
- Reset (BUS_RST_N=0 at a clock edge), taking effect in all states including mid-packet:
  - state = WAIT_HI.
  - FIFO_READ=0, PKT_VALID=0, PKT_DATA=0, all counters=0, timeout counter=0, BUSY=0.
  - The partially stored upper half is lost.
- FIFO_READ is combinational: asserted iff state is WAIT_HI or WAIT_LO, and ENABLE=1, and FIFO_EMPTY=0, and BUS_RST_N=1. The word consumed is the FIFO_DATA present in that same cycle.
- A popped word with FIFO_DATA[31:25] != DATA_IDENTIFIER:
  - ID_ERR_CNT increments; the word is otherwise ignored.
  - State and the timeout counter are unchanged (the timeout keeps running).
- State machine, valid-ID pops only:
  - WAIT_HI, half=1: store payload as upper half, go to WAIT_LO, timeout counter=0.
  - WAIT_HI, half=0: SYNC_ERR_CNT increments, word dropped, stay in WAIT_HI.
  - WAIT_LO, half=0: PKT_DATA <= {upper, payload}, PKT_VALID <= 1 next cycle, go to OUT.
  - WAIT_LO, half=1: SYNC_ERR_CNT increments, old upper half discarded, new payload stored as upper half, timeout counter=0, stay in WAIT_LO.
- Timeout in WAIT_LO:
  - The counter increments every cycle without a valid lower-half pop.
  - When it reaches TIMEOUT_CYCLES: TIMEOUT_CNT increments, upper half discarded, go to WAIT_HI.
  - A valid lower-half pop in the same cycle as expiry wins: the packet is formed and no timeout is counted.
- OUT:
  - PKT_VALID=1 and PKT_DATA are held stable until PKT_READY=1.
  - On handshake: PKT_VALID <= 0, go to WAIT_HI.
  - No pops occur in OUT. Peak throughput is one packet per 3 cycles.
- ENABLE=0 in WAIT_LO: no pops, but the timeout still runs.
- Counters:
  - 8-bit, saturate at 255, never wrap.
  - CNT_CLR has priority over a simultaneous increment (result 0).
  - Counters are independent of the state machine; CNT_CLR does not alter state.
- BUSY is registered with the state.

Test Plan:
- Reset, then words 0x0180_ABCD (ID 0, half 1, payload 0x80ABCD) and 0x0012_3456 (half 0), PKT_READY=1 -> PKT_DATA=0x80ABCD_123456, PKT_VALID for exactly one cycle, FIFO_READ high on exactly 2 cycles, all counters 0.
- Same two words with PKT_READY=0 for 10 cycles then 1 -> PKT_VALID and PKT_DATA stable for 11 cycles; further FIFO words are not popped until the cycle after the handshake.
- Sequence lower, upper A, upper B, lower -> SYNC_ERR_CNT=2; a single packet {B, lower} is emitted.
- TIMEOUT_CYCLES=4; upper half, then FIFO empty for 10 cycles -> TIMEOUT_CNT=1, state WAIT_HI, BUSY=0. A subsequent lower half -> SYNC_ERR_CNT=1, no packet.
- 300 words with ID 5 (DATA_IDENTIFIER=0) -> ID_ERR_CNT saturates at 255. Then CNT_CLR asserted together with another bad word -> ID_ERR_CNT=0.
- Assert BUS_RST_N=0 while in OUT with PKT_VALID=1 -> next cycle PKT_VALID=0, PKT_DATA=0, BUSY=0. A following valid pair assembles correctly.
